// File: rtl/counter14_checker_if.sv
// counter14_checker_if: sample input and statistics readout bundle for counter14_checker
interface counter14_checker_if #(
    parameter int WIDTH = 14,
    parameter int CNT_W = 32
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] good_count;
    logic [15:0]      wrap_count;
    logic [WIDTH-1:0] last_data;
    modport master (
        output data_in, valid_in, clear,
        input  locked, err_pulse, err_count, good_count, wrap_count, last_data
    );
    modport slave (
        input  data_in, valid_in, clear,
        output locked, err_pulse, err_count, good_count, wrap_count, last_data
    );
endinterface

// File: rtl/counter14_checker.sv
// counter14_checker: locks onto a looped-back 0..MAX_VAL counter and tallies match/error/wrap statistics
module counter14_checker #(
    parameter int WIDTH      = 14,
    parameter int MAX_VAL    = 9999,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 32
) (
    input logic clk,
    input logic reset,
    counter14_checker_if.slave bus
);
    localparam int RUN_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int MISS_W = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
    localparam logic [WIDTH-1:0]  MAX     = WIDTH'(MAX_VAL);
    localparam logic [RUN_W-1:0]  LOCK_M1 = RUN_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] LOSS_M1 = MISS_W'(LOSS_COUNT - 1);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, TRACK} state_t;
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ref_q, ref_d, last_q, last_d, nxt;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]  err_q, err_d, good_q, good_d;
    logic [15:0]       wrap_q, wrap_d;
    logic              in_range, match, good_inc, err_inc, wrap_inc;
    assign nxt      = (ref_q == MAX) ? '0 : ref_q + 1'b1;
    assign in_range = bus.data_in <= MAX;
    assign match    = bus.data_in == nxt;
    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        run_d       = run_q;
        miss_d      = miss_q;
        last_d      = last_q;
        err_pulse_d = 1'b0;
        good_inc    = 1'b0;
        err_inc     = 1'b0;
        wrap_inc    = 1'b0;
        if (bus.valid_in) begin
            last_d = bus.data_in;
            case (state_q)
                SEARCH: if (in_range) begin
                    ref_d   = bus.data_in;
                    run_d   = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: if (!in_range) begin
                    state_d = SEARCH;
                end else begin
                    ref_d = bus.data_in;
                    run_d = match ? run_q + 1'b1 : '0;
                    if (match && run_q == LOCK_M1) begin
                        state_d = TRACK;
                        miss_d  = '0;
                    end
                end
                TRACK: if (match) begin
                    good_inc = 1'b1;
                    wrap_inc = ref_q == MAX;
                    miss_d   = '0;
                    ref_d    = bus.data_in;
                end else begin
                    err_pulse_d = 1'b1;
                    err_inc     = 1'b1;
                    ref_d       = in_range ? bus.data_in : ref_q;
                    // out-of-range samples keep the old reference so the next good value can still resync
                    miss_d      = (miss_q == LOSS_M1) ? '0 : miss_q + 1'b1;
                    state_d     = (miss_q == LOSS_M1) ? SEARCH : TRACK;
                end
                default: state_d = SEARCH;
            endcase
        end
        good_d = bus.clear ? '0 : (good_inc && good_q != '1) ? good_q + 1'b1 : good_q;
        err_d  = bus.clear ? '0 : (err_inc && err_q != '1) ? err_q + 1'b1 : err_q;
        wrap_d = bus.clear ? '0 : wrap_inc ? wrap_q + 1'b1 : wrap_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            ref_q       <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            last_q      <= '0;
            err_pulse_q <= 1'b0;
            err_q       <= '0;
            good_q      <= '0;
            wrap_q      <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            last_q      <= last_d;
            err_pulse_q <= err_pulse_d;
            err_q       <= err_d;
            good_q      <= good_d;
            wrap_q      <= wrap_d;
        end
    end
    assign bus.locked     = state_q == TRACK;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_q;
    assign bus.good_count = good_q;
    assign bus.wrap_count = wrap_q;
    assign bus.last_data  = last_q;
endmodule

// File: tb/tb_counter14_checker.sv
// tb_counter14_checker: table-driven directed vectors plus clear/reset corner sequences
module tb_counter14_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int failed = 0;
    always #5 clk = ~clk;
    counter14_checker_if #(.WIDTH(14), .CNT_W(32)) bus ();
    counter14_checker dut (.clk(clk), .reset(reset), .bus(bus.slave));
    typedef struct {
        logic        r, v, c;
        logic [13:0] d;
        logic        l, p;
        logic [31:0] e, g;
        logic [15:0] w;
        logic [13:0] last;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(logic r, logic v, int d, logic c, logic l, logic p,
                                int e, int g, int w, int last);
        vec_t x;
        x.r = r; x.v = v; x.d = 14'(d); x.c = c; x.l = l; x.p = p;
        x.e = 32'(e); x.g = 32'(g); x.w = 16'(w); x.last = 14'(last);
        return x;
    endfunction
    task automatic step(input vec_t x, input string name);
        @(negedge clk);
        reset = x.r; bus.valid_in = x.v; bus.data_in = x.d; bus.clear = x.c;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.locked, bus.err_pulse, bus.err_count, bus.good_count, bus.wrap_count, bus.last_data} !==
            {x.l, x.p, x.e, x.g, x.w, x.last}) begin
            failed++;
            $display("FAIL %s: got locked=%0d pulse=%0d err=%0d good=%0d wrap=%0d last=%0d, want locked=%0d pulse=%0d err=%0d good=%0d wrap=%0d last=%0d",
                     name, bus.locked, bus.err_pulse, bus.err_count, bus.good_count, bus.wrap_count, bus.last_data,
                     x.l, x.p, x.e, x.g, x.w, x.last);
        end
    endtask
    initial begin
        bus.valid_in = 1'b0; bus.data_in = '0; bus.clear = 1'b0;
        // lock from reset on 0..4, then an idle cycle holds everything
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,1,2,0, 0,0,0,0,0,2));
        tbl.push_back(mk(0,1,3,0, 0,0,0,0,0,3));
        tbl.push_back(mk(0,1,4,0, 1,0,0,0,0,4));
        tbl.push_back(mk(0,0,77,0, 1,0,0,0,0,4));
        // wrap through MAX_VAL
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,9993,0, 0,0,0,0,0,9993));
        tbl.push_back(mk(0,1,9994,0, 0,0,0,0,0,9994));
        tbl.push_back(mk(0,1,9995,0, 0,0,0,0,0,9995));
        tbl.push_back(mk(0,1,9996,0, 0,0,0,0,0,9996));
        tbl.push_back(mk(0,1,9997,0, 1,0,0,0,0,9997));
        tbl.push_back(mk(0,1,9998,0, 1,0,0,1,0,9998));
        tbl.push_back(mk(0,1,9999,0, 1,0,0,2,0,9999));
        tbl.push_back(mk(0,1,0,0,    1,0,0,3,1,0));
        tbl.push_back(mk(0,1,1,0,    1,0,0,4,1,1));
        // single glitch then resync
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,96,0,  0,0,0,0,0,96));
        tbl.push_back(mk(0,1,97,0,  0,0,0,0,0,97));
        tbl.push_back(mk(0,1,98,0,  0,0,0,0,0,98));
        tbl.push_back(mk(0,1,99,0,  0,0,0,0,0,99));
        tbl.push_back(mk(0,1,100,0, 1,0,0,0,0,100));
        tbl.push_back(mk(0,1,101,0, 1,0,0,1,0,101));
        tbl.push_back(mk(0,1,150,0, 1,1,1,1,0,150));
        tbl.push_back(mk(0,1,151,0, 1,0,1,2,0,151));
        tbl.push_back(mk(0,0,0,0,   1,0,1,2,0,151));
        // clear alone, then loss of lock and relock
        tbl.push_back(mk(0,0,0,1,   1,0,0,0,0,151));
        tbl.push_back(mk(0,1,500,0, 1,1,1,0,0,500));
        tbl.push_back(mk(0,1,700,0, 1,1,2,0,0,700));
        tbl.push_back(mk(0,1,900,0, 0,1,3,0,0,900));
        tbl.push_back(mk(0,1,10,0,  0,0,3,0,0,10));
        tbl.push_back(mk(0,1,11,0,  0,0,3,0,0,11));
        tbl.push_back(mk(0,1,12,0,  0,0,3,0,0,12));
        tbl.push_back(mk(0,1,13,0,  0,0,3,0,0,13));
        tbl.push_back(mk(0,1,14,0,  1,0,3,0,0,14));
        // out-of-range in SEARCH and ACQUIRE, run restarts at 9
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,12000,0, 0,0,0,0,0,12000));
        tbl.push_back(mk(0,1,5,0,     0,0,0,0,0,5));
        tbl.push_back(mk(0,1,6,0,     0,0,0,0,0,6));
        tbl.push_back(mk(0,1,16000,0, 0,0,0,0,0,16000));
        tbl.push_back(mk(0,1,9,0,     0,0,0,0,0,9));
        tbl.push_back(mk(0,1,10,0,    0,0,0,0,0,10));
        tbl.push_back(mk(0,1,11,0,    0,0,0,0,0,11));
        tbl.push_back(mk(0,1,12,0,    0,0,0,0,0,12));
        tbl.push_back(mk(0,1,13,0,    1,0,0,0,0,13));
        // out-of-range in TRACK keeps ref=13, so 14 still matches
        tbl.push_back(mk(0,1,15000,0, 1,1,1,0,0,15000));
        tbl.push_back(mk(0,1,14,0,    1,0,1,1,0,14));
        repeat (2) @(posedge clk);
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
        // clear together with a matching sample: clear wins, lock kept
        step(mk(0,1,15,1, 1,0,0,0,0,15), "clear_with_match");
        step(mk(0,1,16,0, 1,0,0,1,0,16), "match_after_clear");
        // reset with clear mid-TRACK: reset wins, everything zero
        step(mk(1,1,17,1, 0,0,0,0,0,0), "reset_mid_track");
        step(mk(0,1,17,0, 0,0,0,0,0,17), "search_after_reset");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/counter14_checker.md
Name: counter14_checker

Overview:
- Receive-side companion to the 14-bit GPIO speed-test counter.
- Samples the counter word arriving over the GPIO loopback path and locks onto the 0..MAX_VAL incrementing sequence.
- Checks every subsequent sample against the expected next value and accumulates match, error and wrap statistics for readout.
- Used to measure GPIO link integrity at a given toggle rate.

Parameters:
- WIDTH, 14, data word width.
- MAX_VAL, 9999, terminal count of the transmitted sequence; the sequence wraps to 0 after it.
- LOCK_COUNT, 4, consecutive correct increments required to declare lock.
- LOSS_COUNT, 3, consecutive mismatches in TRACK that drop lock.
- CNT_W, 32, width of the good and error counters.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  sampled counter word from the GPIO receive path.
- valid_in  input  1  data_in is a new sample this cycle.
- clear  input  1  synchronous clear of the statistics counters only.
- locked  output  1  high while in TRACK.
- err_pulse  output  1  one-cycle pulse per mismatch detected in TRACK.
- err_count  output  CNT_W  mismatches seen in TRACK; saturating.
- good_count  output  CNT_W  correct samples seen in TRACK; saturating.
- wrap_count  output  16  MAX_VAL->0 transitions seen in TRACK; wraps modulo 2^16.
- last_data  output  WIDTH  last accepted sample.

Behaviour:
- Reset (reset=1 at a clk edge), regardless of current state:
  - State goes to SEARCH.
  - All outputs and internal registers (ref, run, miss) become 0.
- next(x) = 0 if x==MAX_VAL, else x+1. A sample is out of range if data_in > MAX_VAL.
- Only cycles with valid_in=1 advance the state machine; cycles with valid_in=0 hold everything and err_pulse=0.
- Every accepted sample updates last_data.
- All outputs are registered: the response appears the cycle after the valid sample.
- SEARCH:
  - In-range sample: ref=data_in, run=0, go to ACQUIRE.
  - Out-of-range sample: stay in SEARCH.
- ACQUIRE:
  - data_in==next(ref): ref=data_in, run=run+1. If run+1==LOCK_COUNT, go to TRACK with locked=1 and miss=0.
  - Other in-range value: ref=data_in, run=0, stay in ACQUIRE.
  - Out-of-range value: go to SEARCH.
  - Statistics counters do not change in ACQUIRE.
- TRACK:
  - Match (data_in==next(ref)): good_count+1 (saturating), miss=0, ref=data_in.
  - If the match was MAX_VAL->0, wrap_count also increments by 1.
  - Mismatch (including out-of-range): err_pulse=1 for one cycle, err_count+1 (saturating), miss=miss+1.
  - After a mismatch, ref=data_in if in range, otherwise ref is unchanged (resync).
  - If miss+1==LOSS_COUNT: go to SEARCH, locked=0, miss=0.
- Counters saturate at all-ones and never wrap, except wrap_count, which wraps modulo 2^16.
- clear=1 zeroes err_count, good_count and wrap_count. It does not affect state, locked, ref or last_data.
- If clear and an increment occur in the same cycle, clear wins (counter = 0).
- If reset and clear are both asserted, reset wins.
- LOCK_COUNT=1 is legal: one correct increment locks.

Test Plan:
- Reset, then feed valid samples 0,1,2,3,4 on consecutive cycles -> locked rises the cycle after sample 4; good_count=0, err_count=0.
- Locked at 9997, feed 9998,9999,0,1 -> good_count=4, wrap_count=1, err_pulse never asserts.
- Locked at 100, feed 101,150,151 -> err_pulse high exactly one cycle after 150; err_count=1; 151 is accepted as a match (good_count=2); locked stays 1.
- Locked, feed three consecutive mismatches 500,700,900 -> err_count=3, locked falls after the third sample, state is SEARCH; then 10 followed by the next 4 increments (11..14) relocks.
- In SEARCH, feed 12000 (out of range) -> stays in SEARCH; feed 5,6,9,10,11,12,13 -> the run restarts at 9 and locked rises after 13.
- Locked, assert clear on the same cycle as a matching sample -> all three counters read 0 next cycle and locked stays 1; assert reset mid-TRACK -> all outputs 0 next cycle.
